// File: rtl/bus_responder_pkg.sv
// Shared constants and address decode for bus_responder: IO window, register offsets, default sizes.
package bus_responder_pkg;

    localparam logic [31:0] IO_BASE        = 32'h0003_0000;
    localparam logic [1:0]  IO_SEL         = 2'b11;
    localparam logic [15:0] UART_OFF       = 16'h0000;
    localparam logic [15:0] CLKCNT_OFF     = 16'h0004;
    localparam int          DEF_RAM_ADDR_W = 17;
    localparam int          DEF_TX_DEPTH   = 8;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_UART,
        ACC_CLKCNT,
        ACC_NONE
    } acc_kind_e;

    // ACC_CLKCNT covers the whole 4-byte counter word; the byte lane is mem_a[1:0].
    function automatic acc_kind_e decode_access(input logic [17:0] a);
        logic [15:0] off;
        off = a[15:0] - IO_BASE[15:0];
        if (a[17:16] != IO_SEL)
            return ACC_RAM;
        else if (off == UART_OFF)
            return ACC_UART;
        else if (off[15:2] == CLKCNT_OFF[15:2])
            return ACC_CLKCNT;
        else
            return ACC_NONE;
    endfunction

endpackage

// File: rtl/bus_responder_fifo.sv
// UART transmit FIFO: head-visible queue with registered near-full flag and sticky overflow.
module bus_resp_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       near_full,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          near_full_reg, overflow_reg;
    logic          do_push, do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + CW'(1);
        else if (!do_push && do_pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            near_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg     <= count_next;
            near_full_reg <= (count_next >= CW'(DEPTH - 2));
            if (push && !do_push)
                overflow_reg <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign near_full = near_full_reg;
    assign overflow  = overflow_reg;

endmodule

// File: rtl/bus_responder.sv
// CPU bus responder: byte RAM, UART rx/tx registers, stop register and optional cycle counter.
// Define BUS_RESP_CLKCNT_EN to build the 32-bit cycle counter and its read snapshot.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int RAM_ADDR_W = DEF_RAM_ADDR_W,
    parameter int TX_DEPTH   = DEF_TX_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    acc_kind_e             kind;
    logic                  rd_en, wr_en, stop_hit, push;
    logic [7:0]            push_data, io_rd, cnt_byte;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [TX_CW-1:0]      fifo_count;
    logic                  fifo_full_unused;
    logic                  unused_hi;
    logic [7:0]            ram [0:(1 << RAM_ADDR_W) - 1];

    assign kind      = decode_access(mem_a[17:0]);
    assign rd_en     = rdy && !mem_wr;
    assign wr_en     = rdy && mem_wr;
    assign ram_addr  = mem_a[RAM_ADDR_W-1:0];
    assign unused_hi = ^mem_a[31:18];

    always_ff @(posedge clk) begin
        if (wr_en && kind == ACC_RAM)
            ram[ram_addr] <= mem_dout;
    end

`ifdef BUS_RESP_CLKCNT_EN
    logic [31:0] cyc_cnt_reg, snap_reg;

    // Byte 0 returns the live count while the rest of the word comes from the snapshot
    // taken by that same read, so a multi-cycle word read stays coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_reg <= '0;
            snap_reg    <= '0;
        end else if (rdy) begin
            cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
            if (!mem_wr && kind == ACC_CLKCNT && mem_a[1:0] == 2'b00)
                snap_reg <= cyc_cnt_reg;
        end
    end

    always_comb begin
        if (mem_a[1:0] == 2'b00)
            cnt_byte = cyc_cnt_reg[7:0];
        else
            cnt_byte = snap_reg[{mem_a[1:0], 3'b000} +: 8];
    end
`else
    assign cnt_byte = 8'h00;
`endif

    always_comb begin
        io_rd = 8'h00;
        case (kind)
            ACC_UART:   if (rx_valid) io_rd = rx_data;
            ACC_CLKCNT: io_rd = cnt_byte;
            default:    io_rd = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din      <= 8'h00;
            rx_ready     <= 1'b0;
            program_stop <= 1'b0;
        end else begin
            if (rd_en)
                mem_din <= (kind == ACC_RAM) ? ram[ram_addr] : io_rd;
            rx_ready <= rd_en && kind == ACC_UART && rx_valid;
            if (stop_hit)
                program_stop <= 1'b1;
        end
    end

    // A stop write queues a NUL so the host sees the end of output in-band.
    assign stop_hit  = wr_en && kind == ACC_CLKCNT && mem_a[1:0] == 2'b00;
    assign push      = stop_hit || (wr_en && kind == ACC_UART && mem_dout != 8'h00);
    assign push_data = stop_hit ? 8'h00 : mem_dout;
    assign tx_valid  = (fifo_count != '0);

    bus_resp_fifo #(
        .DEPTH (TX_DEPTH),
        .DW    (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (tx_valid && tx_ready),
        .head      (tx_data),
        .count     (fifo_count),
        .full      (fifo_full_unused),
        .near_full (io_buffer_full),
        .overflow  (tx_overflow)
    );

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 17, byte address width of the internal RAM (128 KB).
REQ-002 SHALL have parameter TX_DEPTH, default 8, UART transmit FIFO entries; power of two, at least 4.
REQ-003 SHALL have the following ports; the clock is clk and the reset is rst, with rst synchronous and active-high:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  CPU run enable; bus ignored when low
- mem_a  in  32  CPU address bus
- mem_dout  in  8  CPU write data
- mem_wr  in  1  1 = write, 0 = read
- mem_din  out  8  read data to CPU
- io_buffer_full  out  1  transmit FIFO near-full
- rx_data  in  8  UART receive byte
- rx_valid  in  1  rx_data holds a byte
- rx_ready  out  1  one-cycle pop of rx_data
- tx_data  out  8  UART transmit byte
- tx_valid  out  1  FIFO head valid
- tx_ready  in  1  UART accepts the head byte
- program_stop  out  1  sticky halt indication
- tx_overflow  out  1  sticky: a write was dropped because the FIFO was full

Function
REQ-004 SHALL decode each access as IO when mem_a[17:16]==2'b11, otherwise as RAM at mem_a[RAM_ADDR_W-1:0].
REQ-005 SHALL sample the bus only in cycles where rdy=1; when rdy=0, no RAM write, no FIFO push, no rx pop, and mem_din holds.
REQ-006 A RAM read SHALL present the byte on mem_din exactly one cycle after the address, registered.
REQ-007 A RAM write SHALL update the byte in the same cycle, and a read of that address in the next cycle SHALL return the new data.
REQ-008 A read of 0x30000 SHALL return rx_data next cycle and pulse rx_ready when rx_valid=1, and SHALL return 8'h00 with no pulse otherwise.
REQ-009 A write of 0x30000 with nonzero data SHALL push the byte into the TX FIFO; a write with data 8'h00 SHALL be ignored.
REQ-010 A write of 0x30004 SHALL set program_stop and push 8'h00 into the FIFO.
REQ-011 The cycle counter SHALL be 32 bits, increment on every rdy=1 cycle, and wrap from 0xFFFFFFFF to 0.
REQ-012 A read of 0x30004 SHALL snapshot the counter and return byte 0; reads of 0x30005..0x30007 SHALL return snapshot bytes 1..3, little-endian.
REQ-013 IO reads at other IO addresses SHALL return 8'h00, and IO writes there SHALL have no effect.
REQ-014 FIFO contract:
- tx_valid = count!=0 and tx_data = head.
- A pop occurs when tx_valid and tx_ready.
- A simultaneous push and pop SHALL leave count unchanged.
- Pointers SHALL wrap modulo TX_DEPTH.
REQ-015 io_buffer_full SHALL be registered and high when count >= TX_DEPTH-2, leaving margin for one in-flight CPU write.
REQ-016 A push with count==TX_DEPTH and no simultaneous pop SHALL be dropped and SHALL set tx_overflow.
REQ-017 The tx pop path SHALL operate regardless of rdy.

Reset
REQ-018 On rst=1 at a clock edge, the following SHALL be cleared:
- mem_din, rx_ready, program_stop, tx_overflow, io_buffer_full
- FIFO count and pointers, cycle counter, snapshot
REQ-019 RAM contents SHALL NOT be cleared by reset, and reset mid-transfer SHALL discard the pending read and all FIFO data.

Configuration
REQ-020 With BUS_RESP_CLKCNT_EN defined, the cycle counter and snapshot SHALL be implemented per REQ-011/012.
REQ-021 Without BUS_RESP_CLKCNT_EN, the counter and snapshot SHALL be removed, reads of 0x30004..0x30007 SHALL return 8'h00, and writes to 0x30004 SHALL still behave per REQ-010.

Structure
REQ-022 A shared package/defines file SHALL hold:
- the IO base 0x30000 and IO_SEL value 2'b11
- the UART offset 0x0 and the counter/stop offset 0x4
- default RAM_ADDR_W and TX_DEPTH
REQ-023 The TX FIFO SHALL be one sub-module, bus_resp_fifo, with push/pop/count/full; decode, RAM, counter and rx logic SHALL stay in bus_responder.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- RAM loopback: write 0xA5 to 0x00100, read 0x00100 next cycle -> mem_din=0xA5 one cycle after the read address.
- rdy gating: hold rdy=0 while driving a write of 0x3C to 0x00200 -> a later read of 0x00200 returns the old value; counter frozen.
- UART out: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx bytes 0x41, 0x42 only; 0x00 never transmitted.
- Backpressure: tx_ready=0, 6 pushes with TX_DEPTH=8 -> io_buffer_full high after the 6th; 9th push -> tx_overflow=1, count stays 8.
- Counter: run 0x123 rdy cycles after reset, read 0x30004..0x30007 -> bytes 0x23, 0x01, 0x00, 0x00 from the snapshot, unaffected by increments between byte reads.
- Stop and reset: write 0x30004 -> program_stop=1 and 0x00 queued; assert rst mid-drain -> tx_valid=0, program_stop=0 on the next cycle.
